// File: rtl/cga_ctrl_regs.sv
// Purpose : CGA-family control registers: mode, colour, ext mode, status, light pen, frame blink.
// Latency : a write is committed 3 clk after bus_iow_l falls; reads are combinational.
// Backpressure: none; exactly one commit per IO write strobe, the ISA bus is never stalled.
//
// Ports:
//   clk, reset_l                          clock, synchronous active-low reset
//   bus_a, bus_aen, bus_ior_l, bus_iow_l  ISA address / DMA enable / IO strobes
//   word, bus_d                           16-bit transfer flag and write data
//   bus_out, bus_dir                      read data and "this block drives the bus"
//   vsync_l, display_enable, lpen_strobe  asynchronous CRTC-side inputs, synchronised here
//   crtc_mem_addr                         CRTC address captured by the light pen
//   ctrl_reg, color_reg, ext_reg          register outputs to crtc6845 / cga_pixel
//   video_enabled                         display enable (forced or from ctrl_reg[3])
//   cursor_blink, char_blink              frame-locked blink phases
//   lpen_addr, lpen_valid                 light-pen latch
module cga_ctrl_regs #(
    parameter logic [15:0] IO_BASE_ADDR        = 16'h03D0,
    parameter logic [7:0]  CTRL_RESET          = 8'h2A,
    parameter logic [7:0]  COLOR_RESET         = 8'h00,
    parameter int unsigned EXT_REG_EN          = 0,
    parameter int unsigned NO_DISPLAY_DISABLE  = 1,
    parameter int unsigned CURSOR_BLINK_FRAMES = 8,
    parameter int unsigned CHAR_BLINK_FRAMES   = 16
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic [15:0] bus_a,
    input  logic        bus_aen,
    input  logic        bus_ior_l,
    input  logic        bus_iow_l,
    input  logic        word,
    input  logic [15:0] bus_d,
    output logic [7:0]  bus_out,
    output logic        bus_dir,
    input  logic        vsync_l,
    input  logic        display_enable,
    input  logic        lpen_strobe,
    input  logic [13:0] crtc_mem_addr,
    output logic [7:0]  ctrl_reg,
    output logic [7:0]  color_reg,
    output logic [7:0]  ext_reg,
    output logic        video_enabled,
    output logic        cursor_blink,
    output logic        char_blink,
    output logic [13:0] lpen_addr,
    output logic        lpen_valid
);

    localparam logic [15:0] ADDR_CTRL   = IO_BASE_ADDR + 16'h0008;
    localparam logic [15:0] ADDR_COLOR  = IO_BASE_ADDR + 16'h0009;
    localparam logic [15:0] ADDR_STATUS = IO_BASE_ADDR + 16'h000A;
    localparam logic [15:0] ADDR_LP_CLR = IO_BASE_ADDR + 16'h000B;
    localparam logic [15:0] ADDR_LP_SET = IO_BASE_ADDR + 16'h000C;
    localparam logic [15:0] ADDR_EXT    = IO_BASE_ADDR + 16'h000D;

    localparam logic [7:0] CURSOR_LAST = 8'(CURSOR_BLINK_FRAMES - 1);
    localparam logic [7:0] CHAR_LAST   = 8'(CHAR_BLINK_FRAMES - 1);
    localparam bit         EXT_ON      = (EXT_REG_EN != 0);

    // Synchroniser chains hold the raw (uninverted) pin level and reset to 0,
    // so a strobe or vsync already low when reset lifts never looks like a
    // fresh falling edge. Bit [1] is the synchronised value, bit [2] its
    // previous-cycle copy for edge detection.
    logic [2:0]  iow_sync_q,  iow_sync_d;
    logic [2:0]  vs_sync_q,   vs_sync_d;
    logic [2:0]  lp_sync_q,   lp_sync_d;
    logic [1:0]  de_sync_q,   de_sync_d;

    logic [7:0]  ctrl_q,      ctrl_d;
    logic [7:0]  color_q,     color_d;
    logic [7:0]  ext_q,       ext_d;
    logic [13:0] lpen_addr_q, lpen_addr_d;
    logic        lpen_vld_q,  lpen_vld_d;
    logic [7:0]  cur_cnt_q,   cur_cnt_d;
    logic [7:0]  chr_cnt_q,   chr_cnt_d;
    logic        cur_blk_q,   cur_blk_d;
    logic        chr_blk_q,   chr_blk_d;

    logic        wr_en;
    logic        frame_tick;
    logic        lpen_edge;
    logic        lpen_clr;
    logic        lpen_set;
    logic [7:0]  status;

    assign wr_en      = iow_sync_q[2] & ~iow_sync_q[1] & ~bus_aen;
    assign frame_tick = vs_sync_q[2] & ~vs_sync_q[1];
    assign lpen_edge  = lp_sync_q[1] & ~lp_sync_q[2];
    assign lpen_clr   = wr_en && (bus_a == ADDR_LP_CLR);
    assign lpen_set   = wr_en && (bus_a == ADDR_LP_SET);
    assign status     = {4'b1111, ~vs_sync_q[1], 1'b1, lpen_vld_q, ~de_sync_q[1]};

    always_comb begin
        iow_sync_d  = {iow_sync_q[1:0], bus_iow_l};
        vs_sync_d   = {vs_sync_q[1:0], vsync_l};
        lp_sync_d   = {lp_sync_q[1:0], lpen_strobe};
        de_sync_d   = {de_sync_q[0], display_enable};
        ctrl_d      = ctrl_q;
        color_d     = color_q;
        ext_d       = ext_q;
        lpen_addr_d = lpen_addr_q;
        lpen_vld_d  = lpen_vld_q;
        cur_cnt_d   = cur_cnt_q;
        chr_cnt_d   = chr_cnt_q;
        cur_blk_d   = cur_blk_q;
        chr_blk_d   = chr_blk_q;

        // A word write to the mode port fills mode and colour together;
        // every other port only ever takes the low byte.
        if (wr_en) begin
            if (bus_a == ADDR_CTRL) begin
                ctrl_d = bus_d[7:0];
                if (word) begin
                    color_d = bus_d[15:8];
                end
            end
            if (bus_a == ADDR_COLOR) begin
                color_d = bus_d[7:0];
            end
            if (EXT_ON && (bus_a == ADDR_EXT)) begin
                ext_d = bus_d[7:0];
            end
        end

        // Clear beats a coincident pen edge; a CPU set overrides the
        // first-hit-holds rule of the pen itself.
        if (lpen_clr) begin
            lpen_vld_d = 1'b0;
        end else if (lpen_set) begin
            lpen_addr_d = crtc_mem_addr;
            lpen_vld_d  = 1'b1;
        end else if (lpen_edge && !lpen_vld_q) begin
            lpen_addr_d = crtc_mem_addr;
            lpen_vld_d  = 1'b1;
        end

        if (frame_tick) begin
            if (cur_cnt_q == CURSOR_LAST) begin
                cur_cnt_d = 8'h00;
                cur_blk_d = ~cur_blk_q;
            end else begin
                cur_cnt_d = cur_cnt_q + 8'h01;
            end
            if (chr_cnt_q == CHAR_LAST) begin
                chr_cnt_d = 8'h00;
                chr_blk_d = ~chr_blk_q;
            end else begin
                chr_cnt_d = chr_cnt_q + 8'h01;
            end
        end
    end

    // Read path uses the raw strobe so data is valid within the ISA read cycle.
    always_comb begin
        bus_out = 8'h00;
        bus_dir = 1'b0;
        if (!bus_aen && !bus_ior_l) begin
            if (bus_a == ADDR_STATUS) begin
                bus_out = status;
                bus_dir = 1'b1;
            end else if (EXT_ON && (bus_a == ADDR_EXT)) begin
                bus_out = ext_q;
                bus_dir = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            iow_sync_q  <= 3'b000;
            vs_sync_q   <= 3'b000;
            lp_sync_q   <= 3'b000;
            de_sync_q   <= 2'b00;
            ctrl_q      <= CTRL_RESET;
            color_q     <= COLOR_RESET;
            ext_q       <= 8'h00;
            lpen_addr_q <= 14'h0000;
            lpen_vld_q  <= 1'b0;
            cur_cnt_q   <= 8'h00;
            chr_cnt_q   <= 8'h00;
            cur_blk_q   <= 1'b0;
            chr_blk_q   <= 1'b0;
        end else begin
            iow_sync_q  <= iow_sync_d;
            vs_sync_q   <= vs_sync_d;
            lp_sync_q   <= lp_sync_d;
            de_sync_q   <= de_sync_d;
            ctrl_q      <= ctrl_d;
            color_q     <= color_d;
            ext_q       <= ext_d;
            lpen_addr_q <= lpen_addr_d;
            lpen_vld_q  <= lpen_vld_d;
            cur_cnt_q   <= cur_cnt_d;
            chr_cnt_q   <= chr_cnt_d;
            cur_blk_q   <= cur_blk_d;
            chr_blk_q   <= chr_blk_d;
        end
    end

    assign ctrl_reg      = ctrl_q;
    assign color_reg     = color_q;
    assign ext_reg       = ext_q;
    assign video_enabled = (NO_DISPLAY_DISABLE != 0) ? 1'b1 : ctrl_q[3];
    assign cursor_blink  = cur_blk_q;
    assign char_blink    = chr_blk_q;
    assign lpen_addr     = lpen_addr_q;
    assign lpen_valid    = lpen_vld_q;

endmodule
